// File: rtl/clock_mode_controller_pkg.sv
// Shared definitions for the clock mode controller: FSM state encoding
// and the mapping from internal state to the externally visible mode code.
package clock_mode_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;

    // Mode code shown to the outside world; the unused encoding reads as RUN.
    function automatic logic [1:0] mode_of(input state_t s);
        logic [1:0] m;
        case (s)
            ST_RUN:      m = MODE_RUN;
            ST_SET_HOUR: m = MODE_SET_HOUR;
            ST_SET_MIN:  m = MODE_SET_MIN;
            default:     m = MODE_RUN;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/button_autorepeat.sv
// Press detector with press-and-hold auto-repeat for one debounced button.
// o_Pulse is combinational: it is high in the cycle of the press, and again
// P_REPEAT_DELAY cycles after the press, then every P_REPEAT_PERIOD cycles
// while the button stays held. i_Clear suppresses the pulse and disarms the
// repeat, so a fresh press is needed afterwards.
module button_autorepeat #(
    parameter int unsigned P_REPEAT_DELAY  = 25_000_000,
    parameter int unsigned P_REPEAT_PERIOD = 5_000_000
) (
    input  logic i_Clock,
    input  logic i_Reset_n,
    input  logic i_Btn,
    input  logic i_Clear,
    output logic o_Pulse
);

    localparam int unsigned RMAX = (P_REPEAT_DELAY > P_REPEAT_PERIOD) ? P_REPEAT_DELAY : P_REPEAT_PERIOD;
    localparam int CW = $clog2(RMAX + 1);
    localparam logic [CW-1:0] LIM_DELAY  = CW'(P_REPEAT_DELAY);
    localparam logic [CW-1:0] LIM_PERIOD = CW'(P_REPEAT_PERIOD);

    logic          prev_r;
    logic          active_r;
    logic          rep_r;
    logic [CW-1:0] cnt_r;
    logic          press_s;
    logic          repeat_s;
    logic [CW-1:0] limit_s;

    assign press_s  = i_Btn & ~prev_r;
    assign limit_s  = rep_r ? LIM_PERIOD : LIM_DELAY;
    assign repeat_s = active_r & i_Btn & (cnt_r == limit_s);
    assign o_Pulse  = ~i_Clear & (press_s | repeat_s);

    // Track previous level and count cycles since the last press/repeat pulse.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            prev_r   <= 1'b1;
            active_r <= 1'b0;
            rep_r    <= 1'b0;
            cnt_r    <= '0;
        end else begin
            prev_r <= i_Btn;
            if (i_Clear || !i_Btn) begin
                active_r <= 1'b0;
                rep_r    <= 1'b0;
                cnt_r    <= '0;
            end else if (press_s) begin
                active_r <= 1'b1;
                rep_r    <= 1'b0;
                cnt_r    <= CW'(1);
            end else if (repeat_s) begin
                rep_r <= 1'b1;
                cnt_r <= CW'(1);
            end else if (active_r && (cnt_r != limit_s)) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: rtl/clock_mode_controller.sv
// Mode sequencer for the clock_counters datapath: RUN lets time advance,
// SET_HOUR / SET_MIN pause seconds and issue single-cycle manual increments
// from the Set button (with auto-repeat), returning to RUN on Mode or after
// an inactivity timeout. All outputs are registered from the next state so
// o_Mode and the enables/blink flags always change together.
module clock_mode_controller
    import clock_mode_controller_pkg::*;
#(
    parameter int unsigned P_REPEAT_DELAY  = 25_000_000,
    parameter int unsigned P_REPEAT_PERIOD = 5_000_000,
    parameter int unsigned P_TIMEOUT_SEC   = 30
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Tick_1Hz,
    input  logic       i_Btn_Mode,
    input  logic       i_Btn_Set,
    output logic       o_Reset_Sec,
    output logic       o_Enable_Increment,
    output logic       o_Enable_Count_Sec,
    output logic       o_Enable_Count_Min,
    output logic       o_Enable_Count_Hour,
    output logic       o_Blink_Hour,
    output logic       o_Blink_Min,
    output logic [1:0] o_Mode
);

    localparam int TW = $clog2(P_TIMEOUT_SEC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(P_TIMEOUT_SEC - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(P_TIMEOUT_SEC);

    state_t        state_r;
    state_t        state_next_s;
    logic          mode_prev_r;
    logic [TW-1:0] tmo_r;
    logic          phase_r;
    logic          phase_next_s;
    logic          mode_press_s;
    logic          in_set_s;
    logic          timeout_s;
    logic          clear_s;
    logic          set_pulse_s;

    assign mode_press_s = i_Btn_Mode & ~mode_prev_r;
    assign in_set_s     = (state_r == ST_SET_HOUR) | (state_r == ST_SET_MIN);
    // The tick that would take the idle count to the limit is the timeout event.
    assign timeout_s    = in_set_s & i_Tick_1Hz & (tmo_r >= TMO_LAST);
    // Set is ignored in RUN and dropped whenever the state is about to change.
    assign clear_s      = ~in_set_s | mode_press_s | timeout_s;

    button_autorepeat #(
        .P_REPEAT_DELAY (P_REPEAT_DELAY),
        .P_REPEAT_PERIOD(P_REPEAT_PERIOD)
    ) u_set_repeat (
        .i_Clock  (i_Clock),
        .i_Reset_n(i_Reset_n),
        .i_Btn    (i_Btn_Set),
        .i_Clear  (clear_s),
        .o_Pulse  (set_pulse_s)
    );

    // Next-state selection: Mode steps the cycle, timeout or illegal state goes to RUN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (mode_press_s) state_next_s = ST_SET_HOUR;
                else              state_next_s = ST_RUN;
            end
            ST_SET_HOUR: begin
                if (mode_press_s)   state_next_s = ST_SET_MIN;
                else if (timeout_s) state_next_s = ST_RUN;
                else                state_next_s = ST_SET_HOUR;
            end
            ST_SET_MIN: begin
                if (mode_press_s)   state_next_s = ST_RUN;
                else if (timeout_s) state_next_s = ST_RUN;
                else                state_next_s = ST_SET_MIN;
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // Blink phase: idle in RUN, snaps visible on an increment, else toggles per tick.
    always_comb begin
        phase_next_s = phase_r;
        if (state_next_s == ST_RUN)  phase_next_s = 1'b0;
        else if (set_pulse_s)        phase_next_s = 1'b0;
        else if (i_Tick_1Hz)         phase_next_s = ~phase_r;
        else                         phase_next_s = phase_r;
    end

    // State, timeout counter, edge-detect history and all registered outputs.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_r             <= ST_RUN;
            mode_prev_r         <= 1'b1;
            tmo_r               <= '0;
            phase_r             <= 1'b0;
            o_Mode              <= MODE_RUN;
            o_Reset_Sec         <= 1'b0;
            o_Enable_Increment  <= 1'b0;
            o_Enable_Count_Sec  <= 1'b0;
            o_Enable_Count_Min  <= 1'b0;
            o_Enable_Count_Hour <= 1'b0;
            o_Blink_Hour        <= 1'b0;
            o_Blink_Min         <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            mode_prev_r <= i_Btn_Mode;
            phase_r     <= phase_next_s;

            if (!in_set_s || mode_press_s || set_pulse_s || (state_next_s == ST_RUN)) begin
                tmo_r <= '0;
            end else if (i_Tick_1Hz && (tmo_r != TMO_MAX)) begin
                tmo_r <= tmo_r + TW'(1);
            end else begin
                tmo_r <= tmo_r;
            end

            o_Mode              <= mode_of(state_next_s);
            o_Reset_Sec         <= ((state_r == ST_SET_MIN) & mode_press_s) | timeout_s;
            o_Enable_Increment  <= set_pulse_s;
            o_Enable_Count_Sec  <= (state_r == ST_RUN) & (state_next_s == ST_RUN) & i_Tick_1Hz;
            o_Enable_Count_Hour <= (state_next_s == ST_RUN) |
                                   ((state_next_s == ST_SET_HOUR) & set_pulse_s);
            o_Enable_Count_Min  <= (state_next_s == ST_RUN) |
                                   ((state_next_s == ST_SET_MIN) & set_pulse_s);
            o_Blink_Hour        <= (state_next_s == ST_SET_HOUR) & phase_next_s;
            o_Blink_Min         <= (state_next_s == ST_SET_MIN) & phase_next_s;
        end
    end

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller with a per-cycle reference model
// and a small counter model of clock_counters fed from the DUT outputs.
module tb_clock_mode_controller;

    localparam int D  = 8;
    localparam int P  = 4;
    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       mode = 1'b0;
    logic       set = 1'b0;
    logic       o_Reset_Sec, o_Enable_Increment, o_Enable_Count_Sec;
    logic       o_Enable_Count_Min, o_Enable_Count_Hour, o_Blink_Hour, o_Blink_Min;
    logic [1:0] o_Mode;

    clock_mode_controller #(
        .P_REPEAT_DELAY (D),
        .P_REPEAT_PERIOD(P),
        .P_TIMEOUT_SEC  (TO)
    ) dut (
        .i_Clock            (clk),
        .i_Reset_n          (rst_n),
        .i_Tick_1Hz         (tick),
        .i_Btn_Mode         (mode),
        .i_Btn_Set          (set),
        .o_Reset_Sec        (o_Reset_Sec),
        .o_Enable_Increment (o_Enable_Increment),
        .o_Enable_Count_Sec (o_Enable_Count_Sec),
        .o_Enable_Count_Min (o_Enable_Count_Min),
        .o_Enable_Count_Hour(o_Enable_Count_Hour),
        .o_Blink_Hour       (o_Blink_Hour),
        .o_Blink_Min        (o_Blink_Min),
        .o_Mode             (o_Mode)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int failed = 0;
    int cnum = 0;
    int tick_cnt = 0;
    int pc = 0;

    // clock_counters stand-in and event logs driven by what the DUT emits
    int sec_cnt = 0, hr_cnt = 0, min_cnt = 0, inc_cnt = 0, rs_cnt = 0, bh_cnt = 0;
    int inc_q[$];

    // reference model state
    int   m_st = 0, m_idle = 0, m_age = 0;
    bit   m_hv = 0, m_ph = 0, m_pm = 1, m_ps = 1;
    logic [8:0] e_vec = '0;

    function automatic logic [8:0] dut_vec();
        return {o_Mode, o_Enable_Increment, o_Enable_Count_Sec, o_Enable_Count_Min,
                o_Enable_Count_Hour, o_Reset_Sec, o_Blink_Hour, o_Blink_Min};
    endfunction

    // Model: what the outputs must be after this edge, from the mode rules.
    always @(posedge clk) begin
        int  nst;
        bit  mp, sp, to, inc;
        pc++;
        if (!rst_n) begin
            m_st = 0; m_idle = 0; m_age = 0; m_hv = 0; m_ph = 0; m_pm = 1; m_ps = 1;
            e_vec = '0;
        end else begin
            mp = mode && !m_pm;
            sp = set && !m_ps;
            m_pm = mode;
            m_ps = set;
            to = (m_st != 0) && tick && (m_idle + 1 >= TO);
            if (m_st == 0)  nst = mp ? 1 : 0;
            else if (mp)    nst = (m_st == 1) ? 2 : 0;
            else if (to)    nst = 0;
            else            nst = m_st;
            inc = 0;
            if (m_st == 0 || nst != m_st || !set) begin
                m_hv = 0;
            end else if (sp) begin
                inc = 1; m_hv = 1; m_age = 0;
            end else if (m_hv) begin
                m_age++;
                if (m_age >= D && ((m_age - D) % P) == 0) inc = 1;
            end
            if (nst == 0 || mp || inc) m_idle = 0;
            else if (tick && m_idle < TO) m_idle++;
            if (nst == 0)  m_ph = 0;
            else if (inc)  m_ph = 0;
            else if (tick) m_ph = !m_ph;
            e_vec = {2'(nst), inc, (m_st == 0 && nst == 0 && tick),
                     (nst == 0 || (nst == 2 && inc)), (nst == 0 || (nst == 1 && inc)),
                     ((m_st == 2 && mp) || to), (nst == 1 && m_ph), (nst == 2 && m_ph)};
            m_st = nst;
        end
    end

    // Compare every cycle just after the edge; also feed the counter stand-in.
    always @(posedge clk) begin
        #1;
        compared++;
        if (dut_vec() !== e_vec) begin
            failed++;
            $display("FAIL cycle_compare pc=%0d got=%b expected=%b (mode,inc,sec,min,hour,rsec,bh,bm)",
                     pc, dut_vec(), e_vec);
        end
        if (o_Enable_Count_Sec) sec_cnt++;
        if (o_Reset_Sec) begin sec_cnt = 0; rs_cnt++; end
        if (o_Enable_Increment) begin inc_cnt++; inc_q.push_back(pc); end
        if (o_Enable_Increment && o_Enable_Count_Hour) hr_cnt++;
        if (o_Enable_Increment && o_Enable_Count_Min) min_cnt++;
        if (o_Blink_Hour) bh_cnt++;
    end

    task automatic check(input string nm, input integer got, input integer exp);
        compared++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        cnum++;
        tick = (cnum % 10 == 0);
        if (tick) tick_cnt++;
    endtask

    task automatic align(input int r);
        while (cnum % 10 != r) cyc();
    endtask

    initial begin
        int p, i0, r0, s0;
        // reset
        repeat (2) cyc();
        check("reset_outputs", dut_vec(), 0);
        cyc();
        rst_n = 1'b1;
        tick_cnt = 0;

        // 1: idle RUN, five seconds counted
        repeat (2) cyc();
        check("run_mode", o_Mode, 0);
        check("run_min_hour", {o_Enable_Count_Min, o_Enable_Count_Hour}, 3);
        check("run_inc", o_Enable_Increment, 0);
        while (tick_cnt < 5) cyc();
        repeat (2) cyc();
        check("run_seconds_5", sec_cnt, 5);

        // 2: SET_HOUR, three taps
        mode = 1'b1; cyc(); mode = 1'b0; cyc();
        check("set_hour_mode", o_Mode, 1);
        for (int k = 0; k < 3; k++) begin
            set = 1'b1; repeat (2) cyc();
            set = 1'b0; repeat (3) cyc();
        end
        check("hours_after_taps", hr_cnt, 3);
        check("inc_pulses_taps", inc_cnt, 3);
        check("seconds_paused", sec_cnt, 5);

        // 3: SET_MIN, hold Set for 20 cycles
        mode = 1'b1; cyc(); mode = 1'b0; cyc();
        check("set_min_mode", o_Mode, 2);
        inc_q.delete();
        set = 1'b1;
        p = pc + 1;
        repeat (20) cyc();
        set = 1'b0;
        repeat (6) cyc();
        check("repeat_pulse_count", inc_q.size(), 4);
        if (inc_q.size() == 4) begin
            check("repeat_at_1", inc_q[0] - p + 1, 1);
            check("repeat_at_9", inc_q[1] - p + 1, 9);
            check("repeat_at_13", inc_q[2] - p + 1, 13);
            check("repeat_at_17", inc_q[3] - p + 1, 17);
        end
        check("minutes_after_hold", min_cnt, 4);

        // 4: leave SET_MIN, seconds cleared then counting
        align(2);
        r0 = rs_cnt;
        mode = 1'b1; cyc(); mode = 1'b0;
        repeat (3) cyc();
        check("back_to_run", o_Mode, 0);
        check("reset_sec_once", rs_cnt - r0, 1);
        check("seconds_cleared", sec_cnt, 0);
        align(5);
        s0 = sec_cnt;
        repeat (20) cyc();
        check("seconds_resume", sec_cnt - s0, 2);

        // 5: inactivity timeout from SET_HOUR
        align(3);
        r0 = rs_cnt;
        mode = 1'b1; cyc(); mode = 1'b0; cyc();
        check("timeout_enter", o_Mode, 1);
        bh_cnt = 0;
        repeat (35) cyc();
        check("timeout_run", o_Mode, 0);
        check("timeout_reset_sec", rs_cnt - r0, 1);
        check("blink_high_cycles", bh_cnt, 10);

        // 6: Mode and Set together, then reset during the hold
        align(3);
        i0 = inc_cnt;
        mode = 1'b1; set = 1'b1; cyc(); mode = 1'b0;
        repeat (14) cyc();
        check("simul_mode", o_Mode, 1);
        check("simul_no_inc", inc_cnt - i0, 0);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", dut_vec(), 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (4) cyc();
        check("held_through_reset_mode", o_Mode, 0);
        check("held_through_reset_inc", inc_cnt - i0, 0);
        set = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
